// File: rtl/sc_stream_decoder.sv
// -----------------------------------------------------------------------------
// sc_stream_decoder
//
// Purpose:
//   Receiving end of a 4-lane stochastic bitstream link. After a start in IDLE,
//   the decoder counts the ones on each lane over a window of 2**WIN_LOG2
//   accepted samples. It then publishes the four counts together with a
//   one-cycle done pulse.
//
// Configuration macro:
//   SC_DECODE_CONTINUOUS_EN
//     Undefined (default): single-shot. Each window needs a start in IDLE.
//     Defined:             after the first start, windows run back-to-back
//                          with no gap. Only rst returns the FSM to IDLE.
//
// Parameters:
//   WIN_LOG2  window length = 2**WIN_LOG2 accepted samples (2..16)
//   OUT_W     result width; holds 0..2**WIN_LOG2 inclusive
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   start      in   1      begins a window when sampled in IDLE
//   bit_valid  in   1      lane bits valid this cycle (counted only in RUN)
//   bit_in     in   4      one stochastic bit per lane, lane i = bit_in[i]
//   dec0..3    out  OUT_W  ones-count of each lane for the last completed window
//   done       out  1      one-cycle pulse: dec0..dec3 updated this cycle
//   busy       out  1      high while in RUN
// -----------------------------------------------------------------------------
module sc_stream_decoder #(
    parameter int WIN_LOG2 = 8,
    parameter int OUT_W    = WIN_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic [3:0]       bit_in,
    output logic [OUT_W-1:0] dec0,
    output logic [OUT_W-1:0] dec1,
    output logic [OUT_W-1:0] dec2,
    output logic [OUT_W-1:0] dec3,
    output logic             done,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [WIN_LOG2-1:0]   samp_q,  samp_d;
    logic [OUT_W-1:0]      cnt_q [4];
    logic [OUT_W-1:0]      cnt_d [4];
    logic [OUT_W-1:0]      dec_q [4];
    logic [OUT_W-1:0]      dec_d [4];
    logic                  done_q,  done_d;

    // The window closes on the sample that finds the sample counter at its
    // all-ones value. The counter then wraps naturally to zero.
    logic last_sample;
    assign last_sample = (samp_q == {WIN_LOG2{1'b1}});

    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Any bit_valid seen in the start cycle is deliberately not counted.
                if (start) begin
                    state_d = RUN;
                    samp_d  = '0;
                    for (int i = 0; i < 4; i++) cnt_d[i] = '0;
                end
            end
            RUN: begin
                if (bit_valid) begin
                    if (last_sample) begin
                        // Fold the final sample straight into the published result.
                        for (int i = 0; i < 4; i++) begin
                            dec_d[i] = cnt_q[i] + OUT_W'(bit_in[i]);
                            cnt_d[i] = '0;
                        end
                        samp_d = '0;
                        done_d = 1'b1;
`ifdef SC_DECODE_CONTINUOUS_EN
                        state_d = RUN;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            cnt_d[i] = cnt_q[i] + OUT_W'(bit_in[i]);
                        end
                        samp_d = samp_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            samp_q  <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
                dec_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
        end
    end

    assign dec0 = dec_q[0];
    assign dec1 = dec_q[1];
    assign dec2 = dec_q[2];
    assign dec3 = dec_q[3];
    assign done = done_q;
    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_sc_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_sc_stream_decoder
//
// Stimulus tasks drive windows of lane bits. A plain per-lane ones tally is
// pushed to a scoreboard queue when the final sample is issued. A separate
// monitor pops that entry and compares it whenever done is seen.
// -----------------------------------------------------------------------------
module tb_sc_stream_decoder;

    localparam int WIN_LOG2 = 8;
    localparam int OUT_W    = WIN_LOG2 + 1;
    localparam int N        = 1 << WIN_LOG2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             bit_valid;
    logic [3:0]       bit_in;
    logic [OUT_W-1:0] dec0, dec1, dec2, dec3;
    logic             done;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;
    int done_expected = 0;
    int exp_q[$];  // four entries per window, lanes 0..3 in order

    sc_stream_decoder #(.WIN_LOG2(WIN_LOG2), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .dec0      (dec0),
        .dec1      (dec1),
        .dec2      (dec2),
        .dec3      (dec3),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: compares every done pulse against the oldest expected window.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_seen++;
            if (exp_q.size() < 4) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pulse");
            end else begin
                int e0, e1, e2, e3;
                e0 = exp_q.pop_front();
                e1 = exp_q.pop_front();
                e2 = exp_q.pop_front();
                e3 = exp_q.pop_front();
                check("dec0", int'(dec0), e0);
                check("dec1", int'(dec1), e1);
                check("dec2", int'(dec2), e2);
                check("dec3", int'(dec3), e3);
`ifdef SC_DECODE_CONTINUOUS_EN
                check("busy_at_done", int'(busy), 1);
`else
                check("busy_at_done", int'(busy), 0);
`endif
            end
            $display("done #%0d: dec=%0d %0d %0d %0d", done_seen, dec0, dec1, dec2, dec3);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 all-ones, 1 alternating 0001/0011, 2 4'h5 with every 3rd cycle
    // invalid, 3 random bits with random valid, 4 constant 4'h2.
    // extra_start pulses start at samples 10 and 100. abort_at > 0 asserts
    // rst once that many samples are accepted.
    task automatic run_window(input int mode, input bit extra_start, input int abort_at,
                              input string name);
        int ones[4];
        int n;
        int cyc;
        logic [3:0] b;
        logic v;
        for (int i = 0; i < 4; i++) ones[i] = 0;
        n = 0;
        cyc = 0;

        start = 1'b1;
`ifdef SC_DECODE_CONTINUOUS_EN
        bit_valid = 1'b0;
`else
        bit_valid = 1'($urandom_range(0, 1));  // must not be counted
`endif
        bit_in = 4'($urandom);
        step();
        start = 1'b0;
        check("busy_in_run", int'(busy), 1);

        while (n < N) begin
            cyc++;
            if (cyc > 8000) begin
                checks++;
                failures++;
                $display("FAIL window_budget: got %0d samples expected %0d", n, N);
                break;
            end
            if (abort_at > 0 && n == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_dec0", int'(dec0), 0);
                check("rst_dec3", int'(dec3), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                step();
                rst = 1'b0;
                bit_valid = 1'b0;
                $display("window %s aborted at sample %0d", name, n);
                return;
            end
            case (mode)
                0:       begin b = 4'hF; v = 1'b1; end
                1:       begin b = (n % 2 == 0) ? 4'b0001 : 4'b0011; v = 1'b1; end
                2:       begin b = 4'h5; v = (cyc % 3 != 0); end
                4:       begin b = 4'h2; v = 1'b1; end
                default: begin b = 4'($urandom); v = ($urandom_range(0, 3) != 0); end
            endcase
            start = extra_start && (n == 10 || n == 100);
            bit_in = b;
            bit_valid = v;
            if (v) begin
                for (int i = 0; i < 4; i++) ones[i] += int'(b[i]);
                n++;
                if (n == N) begin
                    for (int i = 0; i < 4; i++) exp_q.push_back(ones[i]);
                    done_expected++;
                end
            end
            step();
        end
        start = 1'b0;
        bit_valid = 1'b0;
        bit_in = 4'($urandom);
        // done must be visible in the cycle right after the final sample.
        step();
        check("done_latency", done_seen, done_expected);
        step();
        check("single_done", done_seen, done_expected);
`ifndef SC_DECODE_CONTINUOUS_EN
        check("busy_after", int'(busy), 0);
`endif
        $display("window %s: cycles=%0d expected=%0d %0d %0d %0d",
                 name, cyc, ones[0], ones[1], ones[2], ones[3]);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bit_valid = 1'b0;
        bit_in = 4'h0;
        step();
        step();
        check("reset_dec0", int'(dec0), 0);
        check("reset_dec1", int'(dec1), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        step();

        run_window(0, 1'b0, 0, "all_ones");
        run_window(1, 1'b0, 0, "mixed");
        run_window(2, 1'b0, 0, "gapped");
        run_window(3, 1'b1, 0, "start_in_run");
        for (int k = 0; k < 2; k++) run_window(3, 1'b0, 0, "random");
        run_window(0, 1'b0, 150, "mid_reset");
        run_window(4, 1'b0, 0, "after_reset");

        check("done_total", done_seen, done_expected);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
